// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, settle limit
// and the default expected table for circuit 1_1.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SETTLE_MAX = 15;

  // X = A & (B xnor C) with {A,B,C} = vector index
  localparam logic [7:0] EXPECTED_1_1 = 8'h90;

endpackage

// File: rtl/truth_table_sweeper_compare.sv
// Capture side of the sweeper: records each sampled output bit into the
// measured table and tracks mismatch count and the lowest failing index.
module tt_compare
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [N_IN-1:0]      idx,
  input  logic                 dut_out,
  input  logic                 exp_bit,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_out        <= '0;
      mismatch_cnt     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else if (clear) begin
      table_out        <= '0;
      mismatch_cnt     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else if (sample) begin
      table_out[idx] <= dut_out;
      if (dut_out != exp_bit) begin
        mismatch_cnt <= mismatch_cnt + 1'b1;
        // Sweep runs in ascending order, so the first mismatch is the lowest.
        if (!first_fail_valid) begin
          first_fail_idx   <= idx;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a small combinational block in ascending order,
// samples its output after SETTLE hold cycles and checks it against EXPECTED.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = EXPECTED_1_1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec_out,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_valid
);

  localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(2**N_IN - 1);
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  // Control: start is accepted only outside DRIVE and only when abort is low;
  // abort is honoured only in DRIVE. No other handshake on this block.
  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx, idx_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              clear, sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    clear     = 1'b0;
    sample    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          clear     = 1'b1;
        end
      end
      DRIVE: begin
        // Abort cancels any sample due this cycle; idx clears so vec_out reads 0.
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt != SETTLE_CNT) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          sample = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 1'b1;
            cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx is held through DONE, so vec_out keeps showing the last vector there.
  assign vec_out   = idx;
  assign busy      = (state == DRIVE);
  assign vec_valid = busy;
  assign done      = (state == DONE);
  assign pass      = done && (mismatch_cnt == '0);

  tt_compare #(.N_IN(N_IN)) u_compare (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .sample           (sample),
    .idx              (idx),
    .dut_out          (dut_out),
    .exp_bit          (EXPECTED[idx]),
    .table_out        (table_out),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=2 and SETTLE=0) driving a
// behavioural gate model with optional per-vector faults, checked every cycle.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start     [2];
  logic       abort     [2];
  logic       dut_out   [2];
  logic [2:0] vec_out   [2];
  logic       vec_valid [2];
  logic       busy      [2];
  logic       done      [2];
  logic       pass      [2];
  logic [7:0] table_out [2];
  logic [3:0] mismatch_cnt [2];
  logic [2:0] first_fail_idx [2];
  logic       first_fail_valid [2];

  logic [7:0] bad [2];   // bit v set => block under test answers wrongly for vector v
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h90)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .dut_out(dut_out[0]),
    .vec_out(vec_out[0]), .vec_valid(vec_valid[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .table_out(table_out[0]), .mismatch_cnt(mismatch_cnt[0]),
    .first_fail_idx(first_fail_idx[0]), .first_fail_valid(first_fail_valid[0])
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'h90)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .dut_out(dut_out[1]),
    .vec_out(vec_out[1]), .vec_valid(vec_valid[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .table_out(table_out[1]), .mismatch_cnt(mismatch_cnt[1]),
    .first_fail_idx(first_fail_idx[1]), .first_fail_valid(first_fail_valid[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic golden(input logic [2:0] v);
    return v[2] & ~(v[1] ^ v[0]);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) dut_out[i] = golden(vec_out[i]) ^ bad[i][vec_out[i]];
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // behavioural model: a sweep is a run of 8*(SETTLE+1) cycles, cycle k drives
  // vector k/(SETTLE+1) and samples on the last cycle of each vector slot
  bit         m_run  [2];
  bit         m_done [2];
  int         m_k    [2];
  logic [7:0] m_tbl  [2];
  int         m_mc   [2];
  int         m_ffi  [2];
  bit         m_ffv  [2];
  int         ms;
  logic [2:0] mv;
  logic       mdv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_done[i] = 0; m_k[i] = 0; m_tbl[i] = '0;
        m_mc[i] = 0; m_ffi[i] = 0; m_ffv[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ms = settle_of(i) + 1;
        if (m_run[i]) begin
          if (abort[i]) begin
            m_run[i] = 0;
            m_k[i]   = 0;
          end else begin
            mv = 3'(m_k[i] / ms);
            if (m_k[i] % ms == ms - 1) begin
              mdv = golden(mv) ^ bad[i][mv];
              m_tbl[i][mv] = mdv;
              if (mdv != golden(mv)) begin
                m_mc[i]++;
                if (!m_ffv[i]) begin m_ffi[i] = int'(mv); m_ffv[i] = 1; end
              end
            end
            m_k[i]++;
            if (m_k[i] == 8 * ms) begin m_run[i] = 0; m_done[i] = 1; end
          end
        end else if (start[i] && !abort[i]) begin
          m_run[i] = 1; m_done[i] = 0; m_k[i] = 0; m_tbl[i] = '0;
          m_mc[i] = 0; m_ffi[i] = 0; m_ffv[i] = 0;
        end
      end
    end
  end

  function automatic int model_vec(input int i);
    if (m_run[i]) return m_k[i] / (settle_of(i) + 1);
    return m_done[i] ? 7 : 0;
  endfunction

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("vec_out",   i, 32'(vec_out[i]),          32'(model_vec(i)));
        chk("vec_valid", i, 32'(vec_valid[i]),        32'(m_run[i]));
        chk("busy",      i, 32'(busy[i]),             32'(m_run[i]));
        chk("done",      i, 32'(done[i]),             32'(m_done[i]));
        chk("pass",      i, 32'(pass[i]),             32'(m_done[i] && m_mc[i] == 0));
        chk("table_out", i, 32'(table_out[i]),        32'(m_tbl[i]));
        chk("mismatch",  i, 32'(mismatch_cnt[i]),     32'(m_mc[i]));
        chk("ff_idx",    i, 32'(first_fail_idx[i]),   32'(m_ffi[i]));
        chk("ff_valid",  i, 32'(first_fail_valid[i]), 32'(m_ffv[i]));
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input int i);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
  endtask

  // cyc = cycles from the first DRIVE cycle until done is seen high
  task automatic run_sweep(input int i, output int cyc);
    pulse_start(i);
    cyc = 0;
    while (!done[i] && cyc < 200) begin @(negedge clk); cyc++; end
    if (!done[i]) chk("done_timeout", i, 32'(done[i]), 32'd1);
  endtask

  task automatic wait_vec(input int i, input logic [2:0] v);
    int n = 0;
    while (vec_out[i] != v && n < 100) begin @(negedge clk); n++; end
    if (vec_out[i] != v) chk("vec_timeout", i, 32'(vec_out[i]), 32'(v));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, r, i;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin start[k] = 0; abort[k] = 0; bad[k] = '0; end
    #1 rst_n = 1'b0;
    #20;
    @(negedge clk);
    chk("rst_vec_out", 0, 32'(vec_out[0]), 32'd0);
    chk("rst_busy",    0, 32'(busy[0]),    32'd0);
    chk("rst_table",   0, 32'(table_out[0]), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1;

    // correct block, SETTLE=2
    run_sweep(0, cyc);
    chk("t1_cycles",   0, 32'(cyc),             32'd24);
    chk("t1_table",    0, 32'(table_out[0]),    32'h90);
    chk("t1_mismatch", 0, 32'(mismatch_cnt[0]), 32'd0);
    chk("t1_pass",     0, 32'(pass[0]),         32'd1);
    chk("t1_last_vec", 0, 32'(vec_out[0]),      32'd7);

    // faults on vectors 3 and 6
    bad[0] = 8'h48;
    run_sweep(0, cyc);
    chk("t2_table",    0, 32'(table_out[0]),        32'hD8);
    chk("t2_mismatch", 0, 32'(mismatch_cnt[0]),     32'd2);
    chk("t2_ff_idx",   0, 32'(first_fail_idx[0]),   32'd3);
    chk("t2_ff_valid", 0, 32'(first_fail_valid[0]), 32'd1);
    chk("t2_pass",     0, 32'(pass[0]),             32'd0);
    bad[0] = '0;

    // SETTLE=0
    run_sweep(1, cyc);
    chk("t3_cycles", 1, 32'(cyc),          32'd8);
    chk("t3_table",  1, 32'(table_out[1]), 32'h90);
    chk("t3_pass",   1, 32'(pass[1]),      32'd1);

    // abort while vector 5 is driven (first cycle of its slot)
    pulse_start(0);
    wait_vec(0, 3'd5);
    abort[0] = 1'b1;
    @(negedge clk); abort[0] = 1'b0;
    chk("t4_busy",    0, 32'(busy[0]),           32'd0);
    chk("t4_done",    0, 32'(done[0]),           32'd0);
    chk("t4_vec_out", 0, 32'(vec_out[0]),        32'd0);
    chk("t4_partial", 0, 32'(table_out[0][4:0]), 32'h10);
    run_sweep(0, cyc);
    chk("t4_pass", 0, 32'(pass[0]), 32'd1);

    // start during DRIVE is ignored
    pulse_start(0);
    cyc = 0;
    while (vec_out[0] != 3'd2 && cyc < 100) begin @(negedge clk); cyc++; end
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0; cyc++;
    while (!done[0] && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t5_cycles", 0, 32'(cyc), 32'd24);
    // start and abort together in DRIVE
    pulse_start(0);
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; abort[0] = 1'b0;
    chk("t5_abort_busy", 0, 32'(busy[0]), 32'd0);
    chk("t5_abort_done", 0, 32'(done[0]), 32'd0);

    // asynchronous reset mid-sweep
    pulse_start(0);
    wait_vec(0, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vec_out", 0, 32'(vec_out[0]),        32'd0);
    chk("t6_busy",    0, 32'(busy[0]),           32'd0);
    chk("t6_valid",   0, 32'(vec_valid[0]),      32'd0);
    chk("t6_table",   0, 32'(table_out[0]),      32'd0);
    chk("t6_mcnt",    0, 32'(mismatch_cnt[0]),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_sweep(0, cyc);
    chk("t6_pass", 0, 32'(pass[0]), 32'd1);

    // randomized sweeps with faults, spurious starts and aborts
    for (int it = 0; it < 30; it++) begin
      i = $urandom_range(0, 1);
      if (!busy[i]) bad[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      pulse_start(i);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (!busy[i]) break;
        r = $urandom_range(0, 15);
        if (r == 0) begin
          start[i] = 1'b1; @(negedge clk); start[i] = 1'b0;
        end else if (r == 1 && i == 0 && m_k[0] % 3 == 0) begin
          abort[0] = 1'b1; @(negedge clk); abort[0] = 1'b0;
        end
      end
    end
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
